// File: rtl/mem_responder.sv
// Unified instruction/data memory responder: req/ready handshake with fixed wait states.
// Optional misaligned-access detection is enabled by defining MEM_RESP_ALIGN_CHK_EN.
module mem_responder #(
    parameter int unsigned BIT_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [BIT_WIDTH-1:0] addr,
    input  logic [BIT_WIDTH-1:0] wdata,
    output logic [BIT_WIDTH-1:0] rdata,
    output logic                 ready,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_Q = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   we_q;
    logic [ADDR_Q-1:0]      addr_q;
    logic [BIT_WIDTH-1:0]   wdata_q;
    logic [BIT_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  idx;
    logic                   misaligned;
    logic                   commit;

    // Byte address above the word index wraps, so only the low bits are kept.
    assign idx    = addr_q[ADDR_Q-1:2];
    assign commit = (state == ST_WAIT) && (cnt == '0);

`ifdef MEM_RESP_ALIGN_CHK_EN
    assign misaligned = (addr_q[1:0] != 2'b00);
`else
    logic unused_addr_lo;
    assign misaligned     = 1'b0;
    assign unused_addr_lo = ^addr_q[1:0];
`endif

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[BIT_WIDTH-1:ADDR_Q];

    // Storage has no reset; a reset on the commit edge drops the pending write.
    always_ff @(posedge clk) begin
        if (!rst && commit && we_q && !misaligned) begin
            mem[idx] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr[ADDR_Q-1:0];
                        wdata_q <= wdata;
                        cnt     <= CNT_W'(WAIT_CYCLES);
                        busy    <= 1'b1;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        if (!we_q && !misaligned) begin
                            rdata <= mem[idx];
                        end
                        ready <= 1'b1;
                        err   <= misaligned;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder with a transaction-level timing/memory model.
module tb_mem_responder;

    localparam int unsigned BW    = 32;
    localparam int unsigned AW    = 8;
    localparam int unsigned W     = 2;
    localparam int unsigned DEPTH = 256;
`ifdef MEM_RESP_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, req, we;
    logic [BW-1:0] addr, wdata, rdata;
    logic          ready, busy, err;

    always #5 clk = ~clk;

    mem_responder #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Transaction-level model: an accepted request completes W+2 cycles later.
    bit          pend = 1'b0;
    int          left = 0;
    logic        q_we;
    logic [31:0] q_addr, q_wdata;
    logic [31:0] mm [DEPTH];
    bit          mk [DEPTH];
    logic        e_ready, e_busy, e_err;
    logic [31:0] e_rdata;
    bit          rd_known = 1'b1;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            pend = 1'b0; left = 0;
            e_ready = 1'b0; e_busy = 1'b0; e_err = 1'b0; e_rdata = '0;
            rd_known = 1'b1; chk_en = 1'b1;
        end else begin
            e_ready = 1'b0;
            e_err   = 1'b0;
            if (pend && left == 0) begin
                pend = 1'b0;
            end else if (pend) begin
                left--;
                if (left == 0) begin
                    int ix;
                    ix = int'(q_addr[AW+1:2]);
                    e_ready = 1'b1;
                    if (ALIGN && q_addr[1:0] != 2'b00) e_err = 1'b1;
                    else if (q_we) begin mm[ix] = q_wdata; mk[ix] = 1'b1; end
                    else begin e_rdata = mm[ix]; rd_known = mk[ix]; end
                end
            end else if (req) begin
                pend = 1'b1; left = int'(W) + 1;
                q_we = we; q_addr = addr; q_wdata = wdata;
            end
            e_busy = pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 32'(ready), 32'(e_ready));
            check("busy",  32'(busy),  32'(e_busy));
            check("err",   32'(err),   32'(e_err));
            if (rd_known) check("rdata", rdata, e_rdata);
        end
    end

    // Called at posedge+#1 in an idle cycle; returns at posedge+#1 of the next idle cycle.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int lat, output logic e, output int nb);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
        lat = 1; nb = 0;
        while (ready !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) nb++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy === 1'b1) nb++;
        if (lat >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL txn_timeout: got no ready want ready within 40 cycles");
        end
        rd = rdata; e = err;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    int          lat, nb, last, np;
    logic        e;
    logic [31:0] pre [DEPTH];

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_err",   32'(err),   32'h0);
        rst = 1'b0;

        for (int i = 0; i < int'(DEPTH); i++) begin
            pre[i] = $urandom;
            txn(1'b1, 32'(i * 4), pre[i], rd, lat, e, nb);
            check("wr_latency", 32'(lat), 32'd4);
        end

        txn(1'b0, 32'h0, 32'h0, rd, lat, e, nb);
        check("rd0_latency", 32'(lat), 32'd4);
        check("rd0_data", rd, pre[0]);

        txn(1'b1, 32'h10, 32'hDEADBEEF, rd, lat, e, nb);
        check("wr10_busy_span", 32'(nb), 32'd4);
        txn(1'b0, 32'h10, 32'h0, rd, lat, e, nb);
        check("rd10_data", rd, 32'hDEADBEEF);
        check("rd10_busy_span", 32'(nb), 32'd4);

        txn(1'b1, 32'h400, 32'h12345678, rd, lat, e, nb);
        txn(1'b0, 32'h0, 32'h0, rd, lat, e, nb);
        check("wrap_data", rd, 32'h12345678);

        // req held high with inputs churning every cycle
        last = -1; np = 0;
        for (int k = 1; k <= 40; k++) begin
            req = 1'b1; we = 1'($urandom); addr = $urandom; wdata = $urandom;
            @(posedge clk); #1;
            if (ready === 1'b1) begin
                if (last >= 0) check("hold_spacing", 32'(k - last), 32'd5);
                last = k; np++;
            end
        end
        req = 1'b0;
        check("hold_pulses", 32'(np), 32'd8);
        repeat (W + 4) @(posedge clk);
        #1;

        txn(1'b1, 32'h20, 32'h0BADF00D, rd, lat, e, nb);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        np = 0;
        for (int k = 0; k < 8; k++) begin
            if (ready === 1'b1) np++;
            @(posedge clk); #1;
        end
        check("rst_no_ready", 32'(np), 32'd0);
        txn(1'b0, 32'h20, 32'h0, rd, lat, e, nb);
        check("rst_discard", rd, 32'h0BADF00D);

        txn(1'b1, 32'h22, 32'hC0FFEE00, rd, lat, e, nb);
        check("align_err", 32'(e), 32'(ALIGN));
        txn(1'b0, 32'h20, 32'h0, rd, lat, e, nb);
        check("align_mem8", rd, ALIGN ? 32'h0BADF00D : 32'hC0FFEE00);

        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            if ($urandom_range(0, 24) == 0) begin
                req = 1'b1; we = 1'($urandom); addr = $urandom; wdata = $urandom;
                repeat ($urandom_range(1, W + 3)) begin
                    @(posedge clk); #1;
                    req = 1'b0;
                end
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end else begin
                txn(1'($urandom), $urandom, $urandom, rd, lat, e, nb);
            end
        end

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
